spike_encoder: RTL

SPIKE_ENCODER -- requirements
Module: spike_encoder

---
 rtl/spike_enc_pkg.sv | 21 ++
 rtl/spike_encoder_if.sv | 27 ++
 rtl/spike_encoder_phase_acc.sv | 52 +++++
 rtl/spike_encoder.sv | 110 +++++++++++
 4 files changed

// File: rtl/spike_enc_pkg.sv
// Shared definitions for the spike encoder: FSM states, channel default,
// and the dithering LFSR constants used when SPIKE_ENC_LFSR_EN is defined.
package spike_enc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          NCH_DEFAULT = 8;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  // One Fibonacci step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// Spike encoder bus: rate-load handshake, run control and spike outputs.
// Handshake: a rate load transfers on a rising clk edge where load_valid and
// load_ready are both high; load_chan/load_value must be stable while
// load_valid is high, and load_valid may be held across cycles where
// load_ready is low without any transfer taking place.
interface spike_encoder_if #(
  parameter int NCH = 8
);
  logic           load_valid;
  logic           load_ready;
  logic [2:0]     load_chan;
  logic [7:0]     load_value;
  logic           start;
  logic [0:NCH-1] spikes;
  logic           busy;
  logic           done;

  modport master (
    output load_valid, load_chan, load_value, start,
    input  load_ready, spikes, busy, done
  );

  modport slave (
    input  load_valid, load_chan, load_value, start,
    output load_ready, spikes, busy, done
  );
endinterface

// File: rtl/spike_encoder_phase_acc.sv
// One rate channel: holds the 8-bit rate and phase accumulator; the carry
// out of each accumulate becomes the registered spike for that update.
module phase_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en,
  input  logic [7:0] load_value,
  input  logic       init_en,
  input  logic [7:0] init_val,
  input  logic       step_en,
  input  logic       clr_en,
  output logic       spike
);

  logic [7:0] rate_q, rate_d;
  logic [7:0] acc_q, acc_d;
  logic       spike_q, spike_d;
  logic [8:0] sum;

  // Next rate, accumulator and spike; init has priority over step.
  always_comb begin
    rate_d  = rate_q;
    acc_d   = acc_q;
    spike_d = spike_q;
    sum     = {1'b0, acc_q} + {1'b0, rate_q};
    if (load_en) rate_d = load_value;
    if (init_en) begin
      acc_d = init_val;
    end else if (step_en) begin
      spike_d = sum[8];
      acc_d   = sum[7:0];
    end else if (clr_en) begin
      spike_d = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_q  <= '0;
      acc_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      rate_q  <= rate_d;
      acc_q   <= acc_d;
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;

endmodule

// File: rtl/spike_encoder.sv
// Rate-to-spike encoder: NCH phase accumulators run for WINDOW updates after
// start; each accumulator carry is a spike. Optional phase dithering of the
// initial accumulators is enabled by defining SPIKE_ENC_LFSR_EN.
module spike_encoder
  import spike_enc_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int NCH    = NCH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  spike_encoder_if.slave   bus,
  output state_t           dbg_state
);

  localparam logic [15:0] LAST_CNT = 16'(WINDOW - 1);

  state_t      state_q, state_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic           in_idle;
  logic           load_fire;
  logic           init_en;
  logic [0:NCH-1] spk;

  assign in_idle   = (state_q == ST_IDLE);
  assign load_fire = bus.load_valid && in_idle;
  assign init_en   = in_idle && bus.start;

  // FSM next-state; busy/done are registered copies of the next state.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          win_cnt_d = '0;
        end
      end
      ST_RUN: begin
        win_cnt_d = win_cnt_q + 16'd1;
        if (win_cnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // FSM and window counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef SPIKE_ENC_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = lfsr_next(lfsr_q);

  // Free-running dither source, advancing every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [7:0] seed;
`ifdef SPIKE_ENC_LFSR_EN
    // Seed byte for channel i taken from LFSR bit indices wrapped mod 16.
    for (genvar b = 0; b < 8; b++) begin : g_bit
      assign seed[b] = lfsr_q[(8 * i + b) % 16];
    end
`else
    assign seed = '0;
`endif

    phase_acc u_acc (
      .clk        (clk),
      .reset      (reset),
      .load_en    (load_fire && (int'(bus.load_chan) == i)),
      .load_value (bus.load_value),
      .init_en    (init_en),
      .init_val   (seed),
      .step_en    (state_q == ST_RUN),
      .clr_en     (state_q == ST_DONE),
      .spike      (spk[i])
    );
  end

  assign bus.load_ready = in_idle;
  assign bus.spikes     = spk;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign dbg_state      = state_q;

endmodule
